// File: rtl/brew_sequencer.sv
// Brew cycle sequencer: preheat, pre-infuse, soak, brew and settle for one cup,
// with a millisecond timebase, preheat timeout and pressure/temperature supervision.
module brew_sequencer #(
  parameter int TICK_CYCLES        = 50_000,
  parameter int PREHEAT_TIMEOUT_MS = 60_000,
  parameter int STABLE_MS          = 20,
  parameter int PREINFUSE_MS       = 3_000,
  parameter int SOAK_MS            = 2_000,
  parameter int BREW_MS            = 25_000,
  parameter int SETTLE_MS          = 2_000,
  parameter int TEMP_DROP_MS       = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       extra_hot,
  input  logic       keep_warm,
  input  logic       clear_fault,
  input  logic       temp_ready,
  input  logic       pressure_ready,
  output logic       heating_enable,
  output logic       brewing_active,
  output logic [1:0] target_temp_mode,
  output logic       pump_enable,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'b000,
    S_PREHEAT   = 3'b001,
    S_PREINFUSE = 3'b010,
    S_SOAK      = 3'b011,
    S_BREW      = 3'b100,
    S_SETTLE    = 3'b101,
    S_DONE      = 3'b110,
    S_FAULT     = 3'b111
  } state_t;

  localparam int            PW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [16:0]   MS_MAX     = '1;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q;
  logic [16:0]   ms_q, stab_q, drop_q;
  logic [16:0]   ms_inc, stab_inc, drop_inc, dur_ms;
  logic [1:0]    mode_q, mode_d, err_d, tmode_d;
  logic          tick, both_ready, stab_hit, drop_hit, ms_hit, timeout_hit;
  logic          heat_d, brew_d, pump_d, busy_d, done_d, error_d;

  assign tick        = (presc_q == PRESC_LAST);
  assign both_ready  = temp_ready && pressure_ready;
  assign ms_inc      = (ms_q == MS_MAX) ? ms_q : ms_q + 17'd1;
  assign stab_inc    = (stab_q == MS_MAX) ? stab_q : stab_q + 17'd1;
  assign drop_inc    = (drop_q == MS_MAX) ? drop_q : drop_q + 17'd1;
  // Each "hit" fires on the tick that completes the required count.
  assign stab_hit    = tick && both_ready && (stab_inc >= 17'(STABLE_MS));
  assign drop_hit    = tick && !temp_ready && (drop_inc >= 17'(TEMP_DROP_MS));
  assign ms_hit      = tick && (ms_inc >= dur_ms);
  assign timeout_hit = tick && (ms_inc >= 17'(PREHEAT_TIMEOUT_MS));
  assign state       = state_q;

  always_comb begin
    dur_ms = MS_MAX;
    case (state_q)
      S_PREINFUSE: dur_ms = 17'(PREINFUSE_MS);
      S_SOAK:      dur_ms = 17'(SOAK_MS);
      S_BREW:      dur_ms = 17'(BREW_MS);
      S_SETTLE:    dur_ms = 17'(SETTLE_MS);
      default:     dur_ms = MS_MAX;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    err_d   = err_code;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_PREHEAT;
          mode_d  = extra_hot ? 2'b10 : 2'b01;
          err_d   = 2'b00;
        end
      end
      S_PREHEAT: begin
        if (abort)            state_d = S_IDLE;
        else if (stab_hit)    state_d = S_PREINFUSE;
        else if (timeout_hit) begin
          state_d = S_FAULT;
          err_d   = 2'b01;
        end
      end
      S_PREINFUSE, S_SOAK, S_BREW: begin
        if (abort) state_d = S_IDLE;
        else if (!pressure_ready) begin
          state_d = S_FAULT;
          err_d   = 2'b10;
        end else if (drop_hit) begin
          state_d = S_FAULT;
          err_d   = 2'b11;
        end else if (ms_hit) begin
          case (state_q)
            S_PREINFUSE: state_d = S_SOAK;
            S_SOAK:      state_d = S_BREW;
            default:     state_d = S_SETTLE;
          endcase
        end
      end
      S_SETTLE: begin
        if (abort)       state_d = S_IDLE;
        else if (ms_hit) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: if (clear_fault) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge as state.
  always_comb begin
    heat_d  = 1'b0;
    brew_d  = 1'b0;
    pump_d  = 1'b0;
    tmode_d = 2'b00;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_d)
      S_IDLE: begin
        heat_d = keep_warm;
        busy_d = 1'b0;
      end
      S_PREHEAT: begin
        heat_d  = 1'b1;
        tmode_d = mode_d;
      end
      S_PREINFUSE, S_BREW: begin
        heat_d  = 1'b1;
        brew_d  = 1'b1;
        pump_d  = 1'b1;
        tmode_d = mode_d;
      end
      S_SOAK: begin
        heat_d  = 1'b1;
        brew_d  = 1'b1;
        tmode_d = mode_d;
      end
      S_SETTLE: begin
        heat_d  = 1'b1;
        tmode_d = mode_d;
      end
      S_DONE: begin
        heat_d  = 1'b1;
        tmode_d = mode_d;
        done_d  = 1'b1;
      end
      default: begin
        busy_d  = 1'b0;
        error_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      mode_q           <= 2'b00;
      err_code         <= 2'b00;
      heating_enable   <= 1'b0;
      brewing_active   <= 1'b0;
      pump_enable      <= 1'b0;
      target_temp_mode <= 2'b00;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      state_q          <= state_d;
      mode_q           <= mode_d;
      err_code         <= err_d;
      heating_enable   <= heat_d;
      brewing_active   <= brew_d;
      pump_enable      <= pump_d;
      target_temp_mode <= tmode_d;
      busy             <= busy_d;
      done             <= done_d;
      error            <= error_d;
    end
  end

  // All counters restart on a state change, so a dip never carries across phases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      ms_q    <= '0;
      stab_q  <= '0;
      drop_q  <= '0;
    end else if (state_d != state_q) begin
      presc_q <= '0;
      ms_q    <= '0;
      stab_q  <= '0;
      drop_q  <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) ms_q <= ms_inc;
      if (!both_ready) stab_q <= '0;
      else if (tick)   stab_q <= stab_inc;
      if (temp_ready)  drop_q <= '0;
      else if (tick)   drop_q <= drop_inc;
    end
  end

endmodule

// File: doc/brew_sequencer.md
Name: brew_sequencer

Overview:
- Top-level brew cycle sequencer that drives the water temperature/pressure controller (heating_enable, brewing_active, target_temp_mode) and the pump.
- Runs one cup per start request: preheat, pre-infuse, soak, brew, settle.
- Applies timeouts and fault supervision, and reports done/error status to the main UI FSM.
- Sits between the main FSM and the water temperature controller.

Parameters:
- TICK_CYCLES, 50_000, clk cycles per 1 ms timebase tick
- PREHEAT_TIMEOUT_MS, 60_000, max ms in PREHEAT before fault
- STABLE_MS, 20, consecutive ms temp_ready&&pressure_ready required to leave PREHEAT
- PREINFUSE_MS, 3_000, pump-on pre-infusion duration
- SOAK_MS, 2_000, pump-off soak duration
- BREW_MS, 25_000, main extraction duration
- SETTLE_MS, 2_000, post-brew drip/settle duration
- TEMP_DROP_MS, 500, consecutive ms temp_ready low tolerated during pumping

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  level; sampled only in IDLE; begins a cycle
- abort  in  1  level; cancels any active cycle
- extra_hot  in  1  sampled with start: 1 selects mode 10, 0 selects mode 01
- keep_warm  in  1  in IDLE, hold standby heating (mode 00)
- clear_fault  in  1  leaves FAULT
- temp_ready  in  1  from temperature controller
- pressure_ready  in  1  from temperature controller
- heating_enable  out  1  to temperature controller
- brewing_active  out  1  to temperature controller
- target_temp_mode  out  2  to temperature controller
- pump_enable  out  1  water pump actuator
- busy  out  1  state not IDLE/FAULT
- done  out  1  one-cycle pulse on successful completion
- error  out  1  high while in FAULT
- err_code  out  2  01 preheat timeout, 10 pressure lost, 11 temperature lost; holds until next start
- state  out  3  current state encoding, for debug/LCD

Behaviour:
- Reset: state=IDLE (000). All outputs 0: target_temp_mode=00, err_code=00, counters 0.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- Timebase:
  - Prescaler counts 0..TICK_CYCLES-1 and emits a tick on the terminal count.
  - Prescaler and ms counter clear on every state change.
  - A state with duration D is occupied exactly D*TICK_CYCLES cycles.
  - ms counter is 17 bits and saturates, never wraps.
- Encodings: IDLE=000, PREHEAT=001, PREINFUSE=010, SOAK=011, BREW=100, SETTLE=101, DONE=110, FAULT=111.
- IDLE:
  - heating_enable=keep_warm, mode=00, pump=0.
  - On start && !abort: go to PREHEAT, latch mode from extra_hot, clear err_code.
  - abort has priority over simultaneous start.
- PREHEAT:
  - heating_enable=1, mode=latched.
  - The stability counter counts ticks while temp_ready&&pressure_ready; it clears on any cycle either is low.
  - Counter reaching STABLE_MS: go to PREINFUSE.
  - ms counter reaching PREHEAT_TIMEOUT_MS: go to FAULT, err 01.
  - Stability is checked before timeout when both fire on the same cycle.
- PREINFUSE / BREW: pump=1, brewing_active=1, heating_enable=1.
- SOAK: pump=0, brewing_active=1, heating_enable=1.
- Supervision in PREINFUSE/SOAK/BREW:
  - pressure_ready low on any cycle: go to FAULT, err 10, immediately (next edge).
  - temp_ready low for TEMP_DROP_MS consecutive ticks: go to FAULT, err 11. The drop counter clears when temp_ready returns high.
  - Pressure fault has priority over temperature fault, which has priority over duration expiry.
- Durations: PREINFUSE to SOAK after PREINFUSE_MS; SOAK to BREW after SOAK_MS; BREW to SETTLE after BREW_MS.
- SETTLE:
  - pump=0, brewing_active=0, heating_enable=1, no supervision.
  - After SETTLE_MS go to DONE.
- DONE:
  - Single cycle with done=1, then IDLE.
  - start is ignored in DONE; a new cycle needs start to be seen in IDLE.
- FAULT:
  - pump=0, heating_enable=0, brewing_active=0, error=1.
  - start is ignored; clear_fault goes to IDLE.
  - abort has no effect in FAULT.
- abort in PREHEAT..SETTLE: go to IDLE next edge with pump=0 that same edge; no done, err_code unchanged.
- Asynchronous reset mid-cycle: pump drops immediately, returns to IDLE.

Test Plan:
- Common bench parameters: TICK_CYCLES=10, STABLE_MS=2, PREINFUSE_MS=3, SOAK_MS=2, BREW_MS=5, SETTLE_MS=2, PREHEAT_TIMEOUT_MS=20, TEMP_DROP_MS=3.
- Happy path:
  - Stimulus: start with extra_hot=1; temp_ready and pressure_ready go high at 50 cycles.
  - Required: mode=10; PREINFUSE entered 20 cycles after both go high; pump high 30 cycles, low 20, high 50; SETTLE 20 cycles; then exactly one done pulse; then IDLE.
- Preheat timeout: start with temp_ready held 0 → FAULT, err_code=01, error=1 after exactly 200 cycles; start ignored; clear_fault → IDLE.
- Pressure loss: pressure_ready low for 1 cycle mid-BREW → FAULT next edge, err_code=10, pump=0, heating_enable=0.
- Temperature dips:
  - temp_ready low for 2 ticks in BREW, then high → no fault; brew completes normally.
  - temp_ready low for 3 ticks in BREW → FAULT, err_code=11.
- Abort and keep_warm:
  - abort in SOAK → IDLE next edge, done never pulses.
  - start and abort asserted together in IDLE → stays IDLE.
  - keep_warm=1 in IDLE → heating_enable=1, mode=00.
- Reset mid-BREW: rst_n asserted → pump_enable=0 asynchronously; state=000; all outputs at reset values.
